// File: rtl/procb_state_ctrl.sv
// Saved-state controller for the per-thread process_bytes store: tracks which
// threads hold valid state, forwards same-cycle save/restore, and buffers one restored record.

module procb_valid_cell (
    input  logic CLK,
    input  logic RST,
    input  logic ack_hit,
    input  logic save_hit,
    input  logic clear_hit,
    output logic vld,
    output logic set_flip,
    output logic clr_flip
);
    logic vld_nxt;

    // A restore consumes the record even if it was saved in the same cycle.
    always_comb begin
        vld_nxt = vld;
        if (ack_hit)
            vld_nxt = 1'b0;
        else if (save_hit)
            vld_nxt = 1'b1;
        else if (clear_hit)
            vld_nxt = 1'b0;
    end

    assign set_flip = ~vld & vld_nxt;
    assign clr_flip = vld & ~vld_nxt;

    always_ff @(posedge CLK) begin
        if (RST)
            vld <= 1'b0;
        else
            vld <= vld_nxt;
    end
endmodule

module procb_state_ctrl #(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = 3,
    parameter int WIDTH         = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     save_en,
    input  logic [N_THREADS_MSB:0]   save_thread_num,
    input  logic [WIDTH-1:0]         save_din,
    input  logic                     clear_en,
    input  logic [N_THREADS_MSB:0]   clear_thread_num,
    input  logic                     restore_req,
    input  logic [N_THREADS_MSB:0]   restore_thread_num,
    output logic                     restore_ack,
    output logic                     restore_valid,
    input  logic                     restore_rdy,
    output logic [WIDTH-1:0]         restore_dout,
    output logic [N_THREADS_MSB:0]   restore_thread_out,
    output logic                     restore_has_state,
    output logic [N_THREADS_MSB+1:0] saved_cnt,
    output logic                     err_overwrite,
    output logic                     mem_wr_en,
    output logic [N_THREADS_MSB:0]   mem_wr_thread_num,
    output logic [WIDTH-1:0]         mem_din,
    output logic                     mem_rd_en,
    output logic [N_THREADS_MSB:0]   mem_rd_thread_num,
    input  logic [WIDTH-1:0]         mem_dout
);
    localparam int TW = N_THREADS_MSB + 1;
    localparam int CW = N_THREADS_MSB + 2;

    typedef struct packed {
        logic [TW-1:0] thread;
        logic          has_state;
        logic          fwd_sel;
    } rec_meta_t;

    logic [N_THREADS-1:0] valid;
    logic [N_THREADS-1:0] set_flip;
    logic [N_THREADS-1:0] clr_flip;
    logic                 same_thr;
    logic                 fwd_hit;
    logic                 ow_hit;
    rec_meta_t            meta_q;
    rec_meta_t            meta_nxt;
    logic [WIDTH-1:0]     fwd_reg;
    logic [CW-1:0]        inc_cnt;
    logic [CW-1:0]        dec_cnt;
    logic [CW-1:0]        cnt_nxt;

    assign mem_wr_en         = save_en;
    assign mem_wr_thread_num = save_thread_num;
    assign mem_din           = save_din;

    assign restore_ack       = restore_req & (~restore_valid | restore_rdy);
    assign mem_rd_en         = restore_ack;
    assign mem_rd_thread_num = restore_thread_num;

    assign same_thr = (save_thread_num == restore_thread_num);
    // The store reads before it writes, so a same-cycle save must bypass it.
    assign fwd_hit  = restore_ack & save_en & same_thr;
    assign ow_hit   = save_en & valid[save_thread_num] & ~(restore_ack & same_thr);

    genvar gi;
    generate
        for (gi = 0; gi < N_THREADS; gi++) begin : g_cell
            procb_valid_cell u_cell (
                .CLK      (CLK),
                .RST      (RST),
                .ack_hit  (restore_ack & (restore_thread_num == TW'(gi))),
                .save_hit (save_en & (save_thread_num == TW'(gi))),
                .clear_hit(clear_en & (clear_thread_num == TW'(gi))),
                .vld      (valid[gi]),
                .set_flip (set_flip[gi]),
                .clr_flip (clr_flip[gi])
            );
        end
    endgenerate

    always_comb begin
        inc_cnt = '0;
        dec_cnt = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            inc_cnt = inc_cnt + CW'(set_flip[i]);
            dec_cnt = dec_cnt + CW'(clr_flip[i]);
        end
        cnt_nxt = saved_cnt + inc_cnt - dec_cnt;
    end

    always_comb begin
        meta_nxt           = meta_q;
        meta_nxt.thread    = restore_thread_num;
        meta_nxt.has_state = valid[restore_thread_num] | (save_en & same_thr);
        meta_nxt.fwd_sel   = fwd_hit;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            restore_valid <= 1'b0;
            meta_q        <= '0;
            saved_cnt     <= '0;
            err_overwrite <= 1'b0;
        end else begin
            if (restore_ack) begin
                restore_valid <= 1'b1;
                meta_q        <= meta_nxt;
            end else if (restore_rdy) begin
                restore_valid <= 1'b0;
            end
            saved_cnt <= cnt_nxt;
            if (ow_hit)
                err_overwrite <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fwd_hit)
            fwd_reg <= save_din;
    end

    assign restore_thread_out = meta_q.thread;
    assign restore_has_state  = meta_q.has_state;
    assign restore_dout       = meta_q.fwd_sel ? fwd_reg : mem_dout;
endmodule

// File: tb/tb_procb_state_ctrl.sv
// Bench for procb_state_ctrl: behavioural store, scoreboard of expected restore records,
// and directed scenarios for forwarding, backpressure, collisions and reset.

module tb_procb_state_ctrl;
    localparam int NT  = 16;
    localparam int MSB = 3;
    localparam int W   = 32;

    logic           CLK = 1'b0;
    logic           RST;
    logic           save_en, clear_en, restore_req, restore_rdy;
    logic [MSB:0]   save_thread_num, clear_thread_num, restore_thread_num;
    logic [W-1:0]   save_din;
    logic           restore_ack, restore_valid, restore_has_state;
    logic [W-1:0]   restore_dout;
    logic [MSB:0]   restore_thread_out;
    logic [MSB+1:0] saved_cnt;
    logic           err_overwrite;
    logic           mem_wr_en, mem_rd_en;
    logic [MSB:0]   mem_wr_thread_num, mem_rd_thread_num;
    logic [W-1:0]   mem_din, mem_dout;

    typedef struct {
        logic [MSB:0] thr;
        logic [W-1:0] data;
        logic         hs;
        logic         chk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] store [NT];

    always #5 CLK = ~CLK;

    procb_state_ctrl #(.N_THREADS(NT), .N_THREADS_MSB(MSB), .WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .save_en(save_en), .save_thread_num(save_thread_num), .save_din(save_din),
        .clear_en(clear_en), .clear_thread_num(clear_thread_num),
        .restore_req(restore_req), .restore_thread_num(restore_thread_num),
        .restore_ack(restore_ack), .restore_valid(restore_valid), .restore_rdy(restore_rdy),
        .restore_dout(restore_dout), .restore_thread_out(restore_thread_out),
        .restore_has_state(restore_has_state), .saved_cnt(saved_cnt),
        .err_overwrite(err_overwrite),
        .mem_wr_en(mem_wr_en), .mem_wr_thread_num(mem_wr_thread_num), .mem_din(mem_din),
        .mem_rd_en(mem_rd_en), .mem_rd_thread_num(mem_rd_thread_num), .mem_dout(mem_dout)
    );

    // Distributed-RAM store with registered read port (read returns pre-write data).
    always @(posedge CLK) begin
        if (mem_wr_en) store[mem_wr_thread_num] <= mem_din;
        if (mem_rd_en) mem_dout <= store[mem_rd_thread_num];
    end

    // Scoreboard: compare each record as it is handed to the consumer.
    always @(negedge CLK) begin
        if (!RST && restore_valid && restore_rdy) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_record: got thread %0d, none expected", restore_thread_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (restore_thread_out !== e.thr || restore_has_state !== e.hs ||
                    (e.chk && restore_dout !== e.data)) begin
                    n_fail++;
                    $display("FAIL record: got thr=%0d hs=%0b dout=%h, want thr=%0d hs=%0b dout=%h",
                             restore_thread_out, restore_has_state, restore_dout, e.thr, e.hs, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        save_en = 0; clear_en = 0; restore_req = 0;
    endtask

    task automatic push(input logic [MSB:0] thr, input logic [W-1:0] d, input logic hs, input logic chk);
        exp_t e;
        e.thr = thr; e.data = d; e.hs = hs; e.chk = chk;
        q.push_back(e);
    endtask

    task automatic save(input logic [MSB:0] thr, input logic [W-1:0] d);
        save_en = 1; save_thread_num = thr; save_din = d;
        tick();
        save_en = 0;
    endtask

    task automatic check_cnt(input string name, input int want);
        n_checks++;
        if (saved_cnt !== (MSB+2)'(want)) begin
            n_fail++;
            $display("FAIL %s: saved_cnt=%0d want %0d", name, saved_cnt, want);
        end
    endtask

    task automatic check_ack(input string name, input logic want);
        #1;
        n_checks++;
        if (restore_ack !== want) begin
            n_fail++;
            $display("FAIL %s: restore_ack=%0b want %0b", name, restore_ack, want);
        end
    endtask

    task automatic test_reset();
        RST = 1; idle(); restore_rdy = 0;
        save_thread_num = 0; save_din = 0; clear_thread_num = 0; restore_thread_num = 0;
        tick(); tick();
        n_checks++;
        if (restore_valid !== 0 || restore_thread_out !== 0 || restore_has_state !== 0 ||
            err_overwrite !== 0 || mem_rd_en !== 0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b thr=%0d hs=%0b err=%0b rd=%0b want all 0",
                     restore_valid, restore_thread_out, restore_has_state, err_overwrite, mem_rd_en);
        end
        check_cnt("reset_cnt", 0);
        RST = 0;
        save_en = 1; #1;
        n_checks++;
        if (mem_wr_en !== 1) begin
            n_fail++;
            $display("FAIL wr_passthru: mem_wr_en=%0b want 1", mem_wr_en);
        end
        save_en = 0;
        tick();
    endtask

    task automatic test_save_restore();
        save(3, 32'hA5);
        check_cnt("save_cnt", 1);
        tick(); tick();
        restore_req = 1; restore_thread_num = 3; restore_rdy = 1;
        check_ack("restore_ack", 1);
        push(3, 32'hA5, 1, 1);
        tick();
        restore_req = 0;
        n_checks++;
        if (restore_valid !== 1) begin
            n_fail++;
            $display("FAIL restore_latency: restore_valid=%0b want 1", restore_valid);
        end
        check_cnt("restore_cnt", 0);
        tick();
    endtask

    task automatic test_forward();
        save_en = 1; save_thread_num = 5; save_din = 32'h1234;
        restore_req = 1; restore_thread_num = 5; restore_rdy = 1;
        check_ack("fwd_ack", 1);
        push(5, 32'h1234, 1, 1);
        tick();
        idle();
        check_cnt("fwd_cnt", 0);
        // Bit 5 must be clear: a second restore finds no state.
        restore_req = 1; restore_thread_num = 5;
        push(5, 0, 0, 0);
        tick();
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        save(1, 32'h11);
        save(2, 32'h22);
        check_cnt("bp_cnt_pre", 2);
        restore_rdy = 0;
        restore_req = 1; restore_thread_num = 1;
        check_ack("bp_first_ack", 1);
        push(1, 32'h11, 1, 1);
        tick();
        restore_thread_num = 2;
        for (int i = 0; i < 3; i++) begin
            check_ack("bp_stall_ack", 0);
            n_checks++;
            if (restore_valid !== 1 || restore_thread_out !== 1 || restore_dout !== 32'h11) begin
                n_fail++;
                $display("FAIL bp_hold: valid=%0b thr=%0d dout=%h want 1/1/11",
                         restore_valid, restore_thread_out, restore_dout);
            end
            tick();
        end
        restore_rdy = 1;
        check_ack("bp_resume_ack", 1);
        push(2, 32'h22, 1, 1);
        tick();
        idle();
        n_checks++;
        if (restore_valid !== 1 || restore_thread_out !== 2) begin
            n_fail++;
            $display("FAIL bp_second: valid=%0b thr=%0d want 1/2", restore_valid, restore_thread_out);
        end
        tick();
        check_cnt("bp_cnt_post", 0);
    endtask

    task automatic test_overwrite();
        save(7, 32'h70);
        save(7, 32'h77);
        tick(); tick();
        n_checks++;
        if (err_overwrite !== 1) begin
            n_fail++;
            $display("FAIL overwrite_err: err_overwrite=%0b want 1", err_overwrite);
        end
        check_cnt("overwrite_cnt", 1);
        restore_req = 1; restore_thread_num = 7;
        push(7, 32'h77, 1, 1);
        tick();
        idle();
        tick();
        check_cnt("overwrite_drain", 0);
        n_checks++;
        if (err_overwrite !== 1) begin
            n_fail++;
            $display("FAIL overwrite_sticky: err_overwrite=%0b want 1", err_overwrite);
        end
    endtask

    task automatic test_collision();
        save_en = 1; save_thread_num = 2; save_din = 32'h2B;
        clear_en = 1; clear_thread_num = 2;
        restore_req = 1; restore_thread_num = 9;
        check_ack("coll_ack", 1);
        push(9, 0, 0, 0);
        tick();
        idle();
        check_cnt("coll_cnt", 1);
        restore_req = 1; restore_thread_num = 2;
        push(2, 32'h2B, 1, 1);
        tick();
        idle();
        tick();
        check_cnt("coll_drain", 0);
    endtask

    task automatic test_double_drop();
        save(10, 32'hA0);
        save(11, 32'hB0);
        check_cnt("drop_pre", 2);
        clear_en = 1; clear_thread_num = 10;
        restore_req = 1; restore_thread_num = 11;
        push(11, 32'hB0, 1, 1);
        tick();
        idle();
        check_cnt("drop_minus2", 0);
        tick();
    endtask

    task automatic test_rst_mid();
        save(6, 32'h66);
        restore_rdy = 0;
        restore_req = 1; restore_thread_num = 4;
        tick();
        idle();
        n_checks++;
        if (restore_valid !== 1) begin
            n_fail++;
            $display("FAIL rst_pre_valid: restore_valid=%0b want 1", restore_valid);
        end
        RST = 1;
        save_en = 1; save_thread_num = 8; save_din = 32'h88;
        tick();
        RST = 0; save_en = 0;
        n_checks++;
        if (restore_valid !== 0 || err_overwrite !== 0) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%0b err=%0b want 0/0", restore_valid, err_overwrite);
        end
        check_cnt("rst_mid_cnt", 0);
        restore_rdy = 1;
        restore_req = 1; restore_thread_num = 8;
        push(8, 0, 0, 0);
        tick();
        idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < NT; i++) store[i] = '0;
        mem_dout = '0;
        test_reset();
        test_save_restore();
        test_forward();
        test_back_to_back();
        test_overwrite();
        test_collision();
        test_double_drop();
        test_rst_mid();
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d records still expected, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
